flash_burst_ctrl: RTL

Burst sequencer in front of the 16 MiB banked byte-wide flash array. It accepts one read or write command at a time, each covering 1 to 2^LEN_W consecutive bytes. It generates the array's per-byte write-enable, read-enable, address and data strobes, and streams data to and from the requester over valid/ready handshakes. All flash accesses in the design go through this block; nothing else drives the array strobes.

---
 rtl/flash_burst_ctrl.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/flash_burst_ctrl.sv
// flash_burst_ctrl
//   Burst sequencer in front of the banked byte-wide flash array. It takes one
//   read or write command at a time, each covering cmd_len_i+1 consecutive
//   bytes. It drives the per-byte array strobes and streams data to and from
//   the requester over valid/ready handshakes.
//
// State table:
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | waiting for a command; cmd_ready_o high
//   WRITE    | one array write per accepted wr_valid_i byte
//   RD_ISSUE | fl_re_o pulse for the byte at cur_addr
//   RD_WAIT  | array returns fl_rdata_i; captured into rd_data
//   RD_HOLD  | rd_valid_o high until the requester takes the byte
//
// Ports:
//   clk_i, rst_i             clock; synchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake
//   cmd_write_i              1 = write burst, 0 = read burst
//   cmd_addr_i               start byte address ([23:20] bank, [19:0] offset)
//   cmd_len_i                byte count minus one
//   wr_data_i/wr_valid_i/wr_ready_o   write byte stream
//   rd_data_o/rd_valid_o/rd_ready_i   read byte stream (rd_data_o registered)
//   busy_o                   high whenever not IDLE
//   done_o                   one-cycle pulse after the last byte of a burst
//   fl_we_o, fl_re_o, fl_addr_o, fl_wdata_o, fl_rdata_i   flash array side
module flash_burst_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [23:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic [7:0]       wr_data_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  output logic [7:0]       rd_data_o,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             fl_we_o,
  output logic             fl_re_o,
  output logic [23:0]      fl_addr_o,
  output logic [7:0]       fl_wdata_o,
  input  logic [7:0]       fl_rdata_i
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WRITE    = 3'd1,
    RD_ISSUE = 3'd2,
    RD_WAIT  = 3'd3,
    RD_HOLD  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [23:0]        cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [7:0]         rd_data_q, rd_data_d;
  logic               done_q, done_d;

  logic cmd_ready, wr_ready, fl_we, fl_re, rd_valid;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cur_addr_q  <= '0;
      remaining_q <= '0;
      rd_data_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      remaining_q <= remaining_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    remaining_d = remaining_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    cmd_ready   = 1'b0;
    wr_ready    = 1'b0;
    fl_we       = 1'b0;
    fl_re       = 1'b0;
    rd_valid    = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid_i) begin
          cur_addr_d  = cmd_addr_i;
          remaining_d = cmd_len_i;
          state_d     = cmd_write_i ? WRITE : RD_ISSUE;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        fl_we    = wr_valid_i;
        if (wr_valid_i) begin
          // 24-bit add wraps naturally, so bank and top-end crossings need no special case
          cur_addr_d = cur_addr_q + 24'd1;
          if (remaining_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            remaining_d = remaining_q - LEN_W'(1);
          end
        end
      end
      RD_ISSUE: begin
        fl_re   = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        // Only cycle where the array output is driven; it floats otherwise
        rd_data_d = fl_rdata_i;
        state_d   = RD_HOLD;
      end
      RD_HOLD: begin
        rd_valid = 1'b1;
        if (rd_ready_i) begin
          cur_addr_d = cur_addr_q + 24'd1;
          if (remaining_q == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            remaining_d = remaining_q - LEN_W'(1);
            state_d     = RD_ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset is synchronous, so the registers still hold pre-reset values in the
  // cycle rst_i is high; gate everything visible so nothing fires in that cycle.
  assign cmd_ready_o = cmd_ready & ~rst_i;
  assign wr_ready_o  = wr_ready & ~rst_i;
  assign fl_we_o     = fl_we & ~rst_i;
  assign fl_re_o     = fl_re & ~rst_i;
  assign rd_valid_o  = rd_valid & ~rst_i;
  assign busy_o      = (state_q != IDLE) & ~rst_i;
  assign done_o      = done_q & ~rst_i;
  assign fl_addr_o   = rst_i ? 24'd0 : cur_addr_q;
  assign fl_wdata_o  = wr_data_i;
  assign rd_data_o   = rd_data_q;

endmodule
